// File: rtl/cgra_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cgra_streamer_pkg
// Purpose  : Shared widths, AXI response code and FSM state encoding for the
//            CGRA input streamer and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package cgra_streamer_pkg;

  localparam int WORD_W = 32;  // CGRA word width
  localparam int ADDR_W = 32;  // byte address width
  localparam int LEN_W  = 16;  // transfer length / stride width

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Explicitly encoded so the state register width is fixed at 2 bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } streamer_state_e;

endpackage : cgra_streamer_pkg
`default_nettype wire

// File: rtl/cgra_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cgra_stream_fifo
// Purpose  : Synchronous FIFO with first-word fall-through head and an
//            occupancy count. DEPTH must be a power of two (pointers wrap
//            naturally). A push into an empty FIFO appears on head_o on the
//            following cycle.
// Ports    : clk_i/rst_ni  clock, asynchronous active-low reset
//            push_i        write push_data_i (accepted if not full, or if a
//                          pop happens in the same cycle)
//            pop_i         drop the head entry (ignored when empty)
//            head_o        oldest entry (zero after reset)
//            empty_o       no entries stored
//            count_o       number of stored entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module cgra_stream_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : cgra_stream_fifo
`default_nettype wire

// File: rtl/cgra_input_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_input_streamer
// Purpose  : Feeds one CGRA input node. On start, walks a strided byte
//            address sequence, issues single-beat AXI-Lite reads on a 64-bit
//            bus, extracts the addressed 32-bit lane of each response and
//            streams the words out through a small FIFO as valid/ready.
// Ports    : clk_i, rst_ni          clock, asynchronous active-low reset
//            start_i                start pulse (only honoured in IDLE)
//            base_addr_i/size_i/stride_i  transfer description, sampled at start
//            busy_o, done_o, err_o  status (err_o sticky until next start)
//            ar_*                   AXI-Lite read address channel
//            r_*                    AXI-Lite read data channel
//            data_o/valid_o/ready_i word stream to the CGRA node
//            stall_cycles_o         CGRA back-pressure cycle counter
// Config   : `define CGRA_STREAMER_PERF_EN to build the saturating
//            back-pressure counter; otherwise stall_cycles_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_input_streamer
  import cgra_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [LEN_W-1:0]          size_i,
  input  logic [LEN_W-1:0]          stride_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [ADDR_W-1:0]         ar_addr_o,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  output logic [WORD_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [31:0]               stall_cycles_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  streamer_state_e   state_q, state_d;
  logic [LEN_W-1:0]  size_q, size_d;
  logic [LEN_W-1:0]  stride_q, stride_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  consumed_q, consumed_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  data_count;
  logic [CNT_W-1:0]  lane_count;
  logic              data_empty;
  logic              lane_empty;
  logic              lane_head;
  logic [WORD_W-1:0] data_head;
  logic [WORD_W-1:0] r_word;
  logic [SUM_W-1:0]  in_flight;
  logic              start_accept;
  logic              ar_valid;
  logic              ar_hs;
  logic              r_ready;
  logic              r_hs;
  logic              pop;
  logic              busy;

  // Every read in flight owns a FIFO slot, either already filled or reserved
  // by an outstanding AR. This is what lets R run without back-pressure.
  assign in_flight    = SUM_W'(data_count) + SUM_W'(lane_count);
  assign start_accept = (state_q == IDLE) && start_i;
  assign busy         = (state_q == ISSUE) || (state_q == DRAIN);

  // Depends only on registered state, and the credit sum cannot grow while
  // an AR waits (R moves a credit from outstanding to FIFO, pops free one),
  // so valid and address stay stable until the handshake.
  assign ar_valid = (state_q == ISSUE) && (issued_q < size_q) &&
                    (in_flight < SUM_W'(FIFO_DEPTH));
  assign ar_hs    = ar_valid && ar_ready_i;

  // The lane FIFO holds exactly one entry per outstanding read.
  assign r_ready = !lane_empty;
  assign r_hs    = r_valid_i && r_ready;
  assign r_word  = lane_head ? r_data_i[2*WORD_W-1:WORD_W] : r_data_i[WORD_W-1:0];

  assign pop = !data_empty && ready_i;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    stride_d   = stride_q;
    issued_d   = issued_q;
    consumed_d = consumed_q;
    cur_addr_d = cur_addr_q;
    err_d      = err_q;

    if (r_hs && (r_resp_i != AXI_RESP_OKAY)) begin
      err_d = 1'b1;
    end
    if (ar_hs) begin
      cur_addr_d = cur_addr_q + ADDR_W'(stride_q);
      issued_d   = issued_q + LEN_W'(1);
    end
    if (pop) begin
      consumed_d = consumed_q + LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          size_d     = size_i;
          stride_d   = stride_i;
          cur_addr_d = base_addr_i;
          issued_d   = '0;
          consumed_d = '0;
          err_d      = 1'b0;
          state_d    = (size_i != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (ar_hs && (issued_q == size_q - LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (lane_empty && data_empty && (consumed_q == size_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      size_q     <= '0;
      stride_q   <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      cur_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      stride_q   <= stride_d;
      issued_q   <= issued_d;
      consumed_q <= consumed_d;
      cur_addr_q <= cur_addr_d;
      err_q      <= err_d;
    end
  end

  // Remembers which 32-bit half of the 64-bit beat each outstanding read
  // wants; AXI-Lite returns R in AR order, so a FIFO is sufficient.
  cgra_stream_fifo #(
    .WIDTH (1),
    .DEPTH (FIFO_DEPTH)
  ) u_lane_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (ar_hs),
    .push_data_i (cur_addr_q[2]),
    .pop_i       (r_hs),
    .head_o      (lane_head),
    .empty_o     (lane_empty),
    .count_o     (lane_count)
  );

  cgra_stream_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (r_hs),
    .push_data_i (r_word),
    .pop_i       (pop),
    .head_o      (data_head),
    .empty_o     (data_empty),
    .count_o     (data_count)
  );

`ifdef CGRA_STREAMER_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_accept) begin
      stall_cnt_d = '0;
    end else if (busy && !data_empty && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

  assign busy_o     = busy;
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;
  assign ar_addr_o  = {cur_addr_q[ADDR_W-1:3], 3'b000};
  assign ar_valid_o = ar_valid;
  assign r_ready_o  = r_ready;
  assign data_o     = data_head;
  assign valid_o    = !data_empty;

endmodule : cgra_input_streamer
`default_nettype wire

// File: tb/tb_cgra_input_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_input_streamer
// Purpose  : Directed self-checking bench for cgra_input_streamer. A small
//            AXI-Lite slave returns {word(a+4), word(a)} for aligned address
//            a, where word(x) = {x[31:2],2'b00} ^ 32'h5A5A_5A5A.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_input_streamer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] size_i = '0;
  logic [15:0] stride_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] ar_addr_o;
  logic        ar_valid_o;
  logic        ar_ready_i = 1'b0;
  logic [63:0] r_data_i = '0;
  logic [1:0]  r_resp_i = '0;
  logic        r_valid_i = 1'b0;
  logic        r_ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] stall_cycles_o;

  always #5 clk_i = ~clk_i;

  cgra_input_streamer #(
    .FIFO_DEPTH     (4),
    .AXI_DATA_WIDTH (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .size_i         (size_i),
    .stride_i       (stride_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .ar_addr_o      (ar_addr_o),
    .ar_valid_o     (ar_valid_o),
    .ar_ready_i     (ar_ready_i),
    .r_data_i       (r_data_i),
    .r_resp_i       (r_resp_i),
    .r_valid_i      (r_valid_i),
    .r_ready_o      (r_ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .stall_cycles_o (stall_cycles_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
  endfunction

  // transfer description and slave/scoreboard state
  logic [31:0] x_base;
  logic [15:0] x_stride;
  int          cyc = 0;
  logic [31:0] ar_q[$];
  int          ar_t[$];
  logic [31:0] ar_log[16];
  int ar_cnt, r_cnt, pop_cnt, done_cnt, busy_cnt, max_infl, ar_before_pop, done_at;
  int ar_delay, ar_wait, stall_left, err_beat;
  bit ar_holding;
  logic [31:0] held_addr, first_data;

  function automatic logic [31:0] exp_addr(input int i);
    return x_base + 32'(i) * {16'b0, x_stride};
  endfunction

  // One clock: drive slave/sink at the falling edge, then observe what the
  // next rising edge will commit (DUT outputs depend only on its registers).
  task automatic cycle();
    @(negedge clk_i);
    cyc++;
    if (ar_holding) chk("ar_hold", {ar_valid_o, ar_addr_o}, {1'b1, held_addr});
    if (ar_valid_o && ar_wait < ar_delay) begin
      ar_ready_i = 1'b0; ar_wait++; ar_holding = 1'b1; held_addr = ar_addr_o;
    end else begin
      ar_ready_i = 1'b1; ar_wait = 0; ar_holding = 1'b0;
    end
    if (ar_q.size() > 0 && ar_t[0] <= cyc) begin
      r_valid_i = 1'b1;
      r_data_i  = {mem_word(ar_q[0] + 32'd4), mem_word(ar_q[0])};
      r_resp_i  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
    end else begin
      r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00;
    end
    if (valid_o && stall_left > 0) begin
      ready_i = 1'b0; stall_left--;
    end else begin
      ready_i = 1'b1;
    end
    #1;
    if (ar_valid_o && ar_ready_i) begin
      chk("ar_addr", ar_addr_o, exp_addr(ar_cnt) & 32'hFFFF_FFF8);
      if (ar_cnt < 16) ar_log[ar_cnt] = ar_addr_o;
      ar_q.push_back(ar_addr_o);
      ar_t.push_back(cyc + 2);
      ar_cnt++;
    end
    if (pop_cnt == 0) ar_before_pop = ar_cnt;
    if (r_valid_i && r_ready_o) begin
      ar_q.delete(0); ar_t.delete(0); r_cnt++;
    end
    if (valid_o && ready_i) begin
      chk("data", data_o, mem_word(exp_addr(pop_cnt)));
      if (pop_cnt == 0) first_data = data_o;
      pop_cnt++;
    end
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
    if (ar_cnt - pop_cnt > max_infl) max_infl = ar_cnt - pop_cnt;
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] size,
                          input logic [15:0] stride, input int ard, input int stall,
                          input int eb, input int spur_at);
    x_base = base; x_stride = stride; ar_delay = ard; ar_wait = 0; ar_holding = 1'b0;
    stall_left = stall; err_beat = eb;
    ar_cnt = 0; r_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0;
    max_infl = 0; ar_before_pop = 0; done_at = -1; first_data = '0;
    base_addr_i = base; size_i = size; stride_i = stride; start_i = 1'b1;
    for (int k = 1; k <= 600 && done_at < 0; k++) begin
      cycle();
      if (done_o) done_at = k;
      if (k == 1) begin
        chk("err_cleared", err_o, 0);
        chk("busy_at_start", busy_o, size != 16'd0);
      end
      start_i = (k == spur_at);
      if (k == spur_at) begin
        base_addr_i = 32'h0000_0000; size_i = 16'd1; stride_i = 16'd0;
      end
    end
    if (done_at < 0) chk("timeout", 0, 1);
    start_i = 1'b0;
    cycle();
    cycle();
    chk("ar_count", ar_cnt, size);
    chk("pop_count", pop_cnt, size);
    chk("done_pulses", done_cnt, 1);
    chk("idle_after", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_status", {busy_o, done_o, err_o, ar_valid_o, r_ready_o, valid_o}, 0);
    chk("rst_ar_addr", ar_addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_stall", stall_cycles_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;

    // basic stream: aligned, stride 8, all low lanes
    run_xfer(32'h8000_0000, 16'd8, 16'd8, 0, 0, -1, 0);
    chk("basic_first_word", first_data, 32'hDA5A_5A5A);
    chk("basic_ar_last", ar_log[7], 32'h8000_0038);
    chk("basic_err", err_o, 0);

    // lane select: hi, lo, hi, lo
    run_xfer(32'h8100_0004, 16'd4, 16'd4, 0, 0, -1, 0);
    chk("lane_ar0", ar_log[0], 32'h8100_0000);
    chk("lane_ar1", ar_log[1], 32'h8100_0008);
    chk("lane_ar2", ar_log[2], 32'h8100_0008);
    chk("lane_ar3", ar_log[3], 32'h8100_0010);
    chk("lane_first_word", first_data, 32'hDB5A_5A5E);

    // CGRA back-pressure for 20 cycles once data is available
    run_xfer(32'h8000_1000, 16'd10, 16'd4, 0, 20, -1, 0);
    chk("bp_ar_before_pop_le4", ar_before_pop <= 4, 1);
    chk("bp_inflight_le4", max_infl <= 4, 1);
`ifdef CGRA_STREAMER_PERF_EN
    chk("stall_cycles", stall_cycles_o, 32'd20);
`else
    chk("stall_cycles", stall_cycles_o, 32'd0);
`endif

    // AR channel stalled 3 cycles per request
    run_xfer(32'h8000_2000, 16'd6, 16'd12, 3, 0, -1, 0);

    // zero-length transfer
    run_xfer(32'h8000_3000, 16'd0, 16'd4, 0, 0, -1, 0);
    chk("size0_done_latency", done_at, 1);
    chk("size0_busy_le1", busy_cnt <= 1, 1);

    // error on beat 2 plus an ignored start while busy
    run_xfer(32'h8000_4000, 16'd5, 16'd8, 0, 0, 2, 3);
    chk("err_sticky", err_o, 1);

    // new start clears the error
    run_xfer(32'h8000_5000, 16'd3, 16'd4, 0, 0, -1, 0);
    chk("err_after_restart", err_o, 0);

    // asynchronous reset in the middle of ISSUE
    x_base = 32'h8000_6000; x_stride = 16'd8; ar_delay = 3; ar_wait = 0;
    ar_holding = 1'b0; stall_left = 0; err_beat = -1; ar_cnt = 0; r_cnt = 0; pop_cnt = 0;
    base_addr_i = x_base; size_i = 16'd8; stride_i = x_stride; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_ar_valid", ar_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_status", {busy_o, done_o, err_o, ar_valid_o, r_ready_o, valid_o}, 0);
    chk("midrst_ar_addr", ar_addr_o, 0);
    ar_q.delete(); ar_t.delete();
    r_valid_i = 1'b0; ar_ready_i = 1'b0; ar_holding = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;

    // recovery after reset
    run_xfer(32'h8000_7004, 16'd3, 16'd8, 1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cgra_input_streamer
`default_nettype wire
